// File: rtl/execute_pipe_unit.sv
// -----------------------------------------------------------------------------
// execute_pipe_unit
//
// Pipeline register between execute and memory1. Latches the execute results
// into memory1 and issues the dcache request (load/store) over a valid/ready
// handshake. Store data is replicated across byte lanes and byte enables are
// generated from funct3[1:0] and the low address bits.
//
// Optional feature (define MISALIGN_TRAP_EN): misaligned half/word accesses
// are not issued and are flagged on misalign_memory1 instead.
//
// Ports:
//   clock, reset                  core clock, async active-low reset
//   stall_wb                      downstream writeback stall, holds everything
//   flush                         squash the instruction entering memory1
//   *_execute                     execute-stage results and control
//   mem_req_ready                 dcache accepts the request
//   *_memory1                     registered memory1-stage values
//   mem_req_valid/write/addr/data/byte_en   dcache request
//   stall_mem                     request pending and dcache not ready
//   stall_execute                 back-pressure to execute
//   misalign_memory1              (MISALIGN_TRAP_EN only) misaligned access
// -----------------------------------------------------------------------------
module execute_pipe_unit #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDRESS_BITS = 20,
    parameter logic [DATA_WIDTH-1:0] NOP          = 32'h00000013
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall_wb,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   ALU_result_execute,
    input  logic [DATA_WIDTH-1:0]   store_data_execute,
    input  logic                    memRead_execute,
    input  logic                    memWrite_execute,
    input  logic                    opwrite_execute,
    input  logic                    opSel_execute,
    input  logic [4:0]              opReg_execute,
    input  logic [1:0]              next_PC_select_execute,
    input  logic [DATA_WIDTH-1:0]   instruction_execute,
    input  logic [ADDRESS_BITS-1:0] PC_execute,
    input  logic [6:0]              opcode_execute,
    input  logic                    mem_req_ready,
    output logic [DATA_WIDTH-1:0]   ALU_result_memory1,
    output logic [DATA_WIDTH-1:0]   instruction_memory1,
    output logic                    opwrite_memory1,
    output logic                    opSel_memory1,
    output logic [4:0]              opReg_memory1,
    output logic [1:0]              next_PC_select_memory1,
    output logic [ADDRESS_BITS-1:0] PC_memory1,
    output logic [6:0]              opcode_memory1,
    output logic                    mem_req_valid,
    output logic                    mem_req_write,
    output logic [ADDRESS_BITS-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [3:0]              mem_req_byte_en,
    output logic                    stall_mem,
    output logic                    stall_execute
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                    misalign_memory1
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e r_state;
    state_e w_state_next;

    logic [DATA_WIDTH-1:0]   r_alu_result;
    logic [DATA_WIDTH-1:0]   r_instruction;
    logic                    r_opwrite;
    logic                    r_opsel;
    logic [4:0]              r_opreg;
    logic [1:0]              r_next_pc_sel;
    logic [ADDRESS_BITS-1:0] r_pc;
    logic [6:0]              r_opcode;
    logic                    r_mem_write;
    logic [DATA_WIDTH-1:0]   r_mem_data;
    logic [3:0]              r_byte_en;

    logic [2:0]            w_funct3;
    logic [1:0]            w_addr_lo;
    logic                  w_is_mem;
    logic                  w_issue;
    logic                  w_advance;
    logic [3:0]            w_byte_en;
    logic [DATA_WIDTH-1:0] w_store_data;

    assign w_funct3  = instruction_execute[14:12];
    assign w_addr_lo = ALU_result_execute[1:0];
    assign w_is_mem  = memRead_execute | memWrite_execute;

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign;

    // funct3[1] selects word, funct3[1:0]==01 selects half.
    assign w_misalign = w_is_mem &
                        (((w_funct3[1:0] == 2'b01) & w_addr_lo[0]) |
                         (w_funct3[1] & (w_addr_lo != 2'b00)));
    assign w_issue = w_is_mem & ~flush & ~w_misalign;
    assign misalign_memory1 = r_misalign;
`else
    assign w_issue = w_is_mem & ~flush;
`endif

    // Lane alignment: byte and half replicate the low data across the word.
    always_comb begin
        w_byte_en    = 4'b0000;
        w_store_data = '0;
        if (w_funct3[1]) begin
            w_byte_en    = 4'b1111;
            w_store_data = store_data_execute;
        end else if (w_funct3[0]) begin
            w_byte_en    = 4'b0011 << {w_addr_lo[1], 1'b0};
            w_store_data = {(DATA_WIDTH/16){store_data_execute[15:0]}};
        end else begin
            w_byte_en    = 4'b0001 << w_addr_lo;
            w_store_data = {(DATA_WIDTH/8){store_data_execute[7:0]}};
        end
    end

    assign w_advance = ~stall_wb & ~stall_mem;

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state. An accepted request under stall_wb parks in StDone so it
    // is not re-issued; a stalled StIssue ignores flush since advance is low.
    always_comb begin
        w_state_next = r_state;
        if (w_advance) begin
            w_state_next = w_issue ? StIssue : StIdle;
        end else if ((r_state == StIssue) && mem_req_ready) begin
            w_state_next = StDone;
        end
    end

    // FSM outputs
    always_comb begin
        mem_req_valid = (r_state == StIssue);
        stall_mem     = mem_req_valid & ~mem_req_ready;
    end

    assign stall_execute = stall_wb | stall_mem;

    // memory1 stage registers; both stall sources hold via w_advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_alu_result  <= '0;
            r_instruction <= NOP;
            r_opwrite     <= 1'b0;
            r_opsel       <= 1'b0;
            r_opreg       <= 5'd0;
            r_next_pc_sel <= 2'd0;
            r_pc          <= '0;
            r_opcode      <= 7'h13;
            r_mem_write   <= 1'b0;
            r_mem_data    <= '0;
            r_byte_en     <= 4'b0000;
`ifdef MISALIGN_TRAP_EN
            r_misalign    <= 1'b0;
`endif
        end else if (w_advance) begin
            if (flush) begin
                r_alu_result  <= '0;
                r_instruction <= NOP;
                r_opwrite     <= 1'b0;
                r_opsel       <= 1'b0;
                r_opreg       <= 5'd0;
                r_next_pc_sel <= 2'd0;
                r_pc          <= '0;
                r_opcode      <= 7'h13;
                r_mem_write   <= 1'b0;
                r_mem_data    <= '0;
                r_byte_en     <= 4'b0000;
`ifdef MISALIGN_TRAP_EN
                r_misalign    <= 1'b0;
`endif
            end else begin
                r_alu_result  <= ALU_result_execute;
                r_instruction <= instruction_execute;
                r_opwrite     <= opwrite_execute;
                r_opsel       <= opSel_execute;
                r_opreg       <= opReg_execute;
                r_next_pc_sel <= next_PC_select_execute;
                r_pc          <= PC_execute;
                r_opcode      <= opcode_execute;
                r_mem_write   <= memWrite_execute;
                r_mem_data    <= memWrite_execute ? w_store_data : '0;
                r_byte_en     <= w_is_mem ? w_byte_en : 4'b0000;
`ifdef MISALIGN_TRAP_EN
                r_misalign    <= w_misalign;
`endif
            end
        end
    end

    assign ALU_result_memory1     = r_alu_result;
    assign instruction_memory1    = r_instruction;
    assign opwrite_memory1        = r_opwrite;
    assign opSel_memory1          = r_opsel;
    assign opReg_memory1          = r_opreg;
    assign next_PC_select_memory1 = r_next_pc_sel;
    assign PC_memory1             = r_pc;
    assign opcode_memory1         = r_opcode;
    assign mem_req_write          = r_mem_write;
    assign mem_req_addr           = r_alu_result[ADDRESS_BITS-1:0];
    assign mem_req_data           = r_mem_data;
    assign mem_req_byte_en        = r_byte_en;

endmodule

// File: tb/tb_execute_pipe_unit.sv
module tb_execute_pipe_unit;

    localparam logic [31:0] NOP_I  = 32'h00000013;
    localparam logic [31:0] ADDI_I = 32'h00100093;

    logic        clock, reset, stall_wb, flush;
    logic [31:0] ALU_result_execute, store_data_execute, instruction_execute;
    logic        memRead_execute, memWrite_execute, opwrite_execute, opSel_execute;
    logic [4:0]  opReg_execute;
    logic [1:0]  next_PC_select_execute;
    logic [19:0] PC_execute;
    logic [6:0]  opcode_execute;
    logic        mem_req_ready;
    logic [31:0] ALU_result_memory1, instruction_memory1;
    logic        opwrite_memory1, opSel_memory1;
    logic [4:0]  opReg_memory1;
    logic [1:0]  next_PC_select_memory1;
    logic [19:0] PC_memory1;
    logic [6:0]  opcode_memory1;
    logic        mem_req_valid, mem_req_write;
    logic [19:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_byte_en;
    logic        stall_mem, stall_execute;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [19:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;
    req_t sb[$];

    execute_pipe_unit dut (
        .clock(clock), .reset(reset), .stall_wb(stall_wb), .flush(flush),
        .ALU_result_execute(ALU_result_execute), .store_data_execute(store_data_execute),
        .memRead_execute(memRead_execute), .memWrite_execute(memWrite_execute),
        .opwrite_execute(opwrite_execute), .opSel_execute(opSel_execute),
        .opReg_execute(opReg_execute), .next_PC_select_execute(next_PC_select_execute),
        .instruction_execute(instruction_execute), .PC_execute(PC_execute),
        .opcode_execute(opcode_execute), .mem_req_ready(mem_req_ready),
        .ALU_result_memory1(ALU_result_memory1), .instruction_memory1(instruction_memory1),
        .opwrite_memory1(opwrite_memory1), .opSel_memory1(opSel_memory1),
        .opReg_memory1(opReg_memory1), .next_PC_select_memory1(next_PC_select_memory1),
        .PC_memory1(PC_memory1), .opcode_memory1(opcode_memory1),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_byte_en(mem_req_byte_en), .stall_mem(stall_mem),
        .stall_execute(stall_execute)
`ifdef MISALIGN_TRAP_EN
        , .misalign_memory1(misalign)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: every accepted handshake must match the oldest expected request.
    always @(negedge clock) begin
        if (reset === 1'b1 && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
            req_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: request addr=%h accepted, none expected", mem_req_addr);
            end else begin
                e = sb.pop_front();
                n_checks += 3;
                if (mem_req_addr !== e.addr) begin
                    n_errors++;
                    $display("FAIL sb_addr: got %h want %h", mem_req_addr, e.addr);
                end
                if (mem_req_write !== e.wr) begin
                    n_errors++;
                    $display("FAIL sb_write: got %b want %b", mem_req_write, e.wr);
                end
                if (mem_req_byte_en !== e.be) begin
                    n_errors++;
                    $display("FAIL sb_byte_en: got %b want %b", mem_req_byte_en, e.be);
                end
                if (e.wr) begin
                    n_checks++;
                    if (mem_req_data !== e.data) begin
                        n_errors++;
                        $display("FAIL sb_data: got %h want %h", mem_req_data, e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_alu();
        memRead_execute = 0; memWrite_execute = 0; flush = 0;
        opwrite_execute = 1; opSel_execute = 0; opReg_execute = 5'd1;
        instruction_execute = ADDI_I; opcode_execute = 7'h13;
        ALU_result_execute = 32'h1; store_data_execute = 32'h0;
        next_PC_select_execute = 2'd0; PC_execute = PC_execute + 20'd4;
    endtask

    task automatic drive_mem(input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] d);
        memRead_execute = ~st; memWrite_execute = st; flush = 0;
        opwrite_execute = ~st; opSel_execute = ~st; opReg_execute = st ? 5'd0 : 5'd5;
        opcode_execute = st ? 7'h23 : 7'h03;
        instruction_execute = {17'h0, f3, (st ? 5'd0 : 5'd5), (st ? 7'h23 : 7'h03)};
        ALU_result_execute = addr; store_data_execute = d;
        next_PC_select_execute = 2'd0; PC_execute = PC_execute + 20'd4;
    endtask

    task automatic push(input logic [19:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] be);
        req_t e;
        e.addr = a; e.wr = w; e.data = d; e.be = be;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_checks += 6;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", mem_req_valid); end
        if (instruction_memory1 !== NOP_I) begin n_errors++; $display("FAIL rst_instr: got %h want %h", instruction_memory1, NOP_I); end
        if (opcode_memory1 !== 7'h13) begin n_errors++; $display("FAIL rst_opcode: got %h want 13", opcode_memory1); end
        if (mem_req_byte_en !== 4'b0 || mem_req_data !== 32'h0 || mem_req_write !== 1'b0) begin
            n_errors++; $display("FAIL rst_req: be=%b data=%h wr=%b want 0", mem_req_byte_en, mem_req_data, mem_req_write);
        end
        if (ALU_result_memory1 !== 32'h0 || opwrite_memory1 !== 1'b0 || opReg_memory1 !== 5'd0) begin
            n_errors++; $display("FAIL rst_regs: alu=%h opw=%b opreg=%0d want 0", ALU_result_memory1, opwrite_memory1, opReg_memory1);
        end
        if (stall_mem !== 1'b0) begin n_errors++; $display("FAIL rst_stall_mem: got %b want 0", stall_mem); end
        @(negedge clock);
        reset = 1;
        step();
    endtask

    task automatic test_sw();
        drive_mem(1, 3'b010, 32'h100, 32'hDEADBEEF);
        push(20'h100, 1, 32'hDEADBEEF, 4'b1111);
        step();
        drive_alu();
        n_checks += 5;
        if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL sw_valid: got %b want 1", mem_req_valid); end
        if (mem_req_write !== 1'b1) begin n_errors++; $display("FAIL sw_write: got %b want 1", mem_req_write); end
        if (mem_req_byte_en !== 4'b1111) begin n_errors++; $display("FAIL sw_be: got %b want 1111", mem_req_byte_en); end
        if (mem_req_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL sw_data: got %h want deadbeef", mem_req_data); end
        if (stall_mem !== 1'b0) begin n_errors++; $display("FAIL sw_stall_mem: got %b want 0", stall_mem); end
        step();
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL sw_pulse: got %b want 0", mem_req_valid); end
    endtask

    task automatic test_sb_backpressure();
        drive_mem(1, 3'b000, 32'h103, 32'h123456AB);
        mem_req_ready = 0;
        push(20'h103, 1, 32'hABABABAB, 4'b1000);
        step();
        drive_alu();
        for (int i = 0; i < 3; i++) begin
            n_checks += 5;
            if (stall_mem !== 1'b1) begin n_errors++; $display("FAIL sb_stall_mem[%0d]: got %b want 1", i, stall_mem); end
            if (stall_execute !== 1'b1) begin n_errors++; $display("FAIL sb_stall_ex[%0d]: got %b want 1", i, stall_execute); end
            if (mem_req_byte_en !== 4'b1000) begin n_errors++; $display("FAIL sb_be[%0d]: got %b want 1000", i, mem_req_byte_en); end
            if (mem_req_data !== 32'hABABABAB) begin n_errors++; $display("FAIL sb_data[%0d]: got %h want abababab", i, mem_req_data); end
            if (instruction_memory1 !== 32'h00000023) begin n_errors++; $display("FAIL sb_hold[%0d]: got %h want 00000023", i, instruction_memory1); end
            if (i < 2) step();
        end
        mem_req_ready = 1;
        #1;
        n_checks++;
        if (stall_mem !== 1'b0) begin n_errors++; $display("FAIL sb_ready_comb: got %b want 0", stall_mem); end
        step();
        n_checks += 2;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL sb_done_valid: got %b want 0", mem_req_valid); end
        if (instruction_memory1 !== ADDI_I) begin n_errors++; $display("FAIL sb_advance: got %h want %h", instruction_memory1, ADDI_I); end
    endtask

    task automatic test_lw_stall_wb();
        drive_mem(0, 3'b010, 32'h200, 32'h0);
        push(20'h200, 0, 32'h0, 4'b1111);
        step();
        drive_alu();
        stall_wb = 1;
        step();
        n_checks += 4;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL lw_done_valid: got %b want 0", mem_req_valid); end
        if (instruction_memory1 !== 32'h00002283) begin n_errors++; $display("FAIL lw_hold: got %h want 00002283", instruction_memory1); end
        if (stall_execute !== 1'b1) begin n_errors++; $display("FAIL lw_stall_ex: got %b want 1", stall_execute); end
        if (stall_mem !== 1'b0) begin n_errors++; $display("FAIL lw_stall_mem: got %b want 0", stall_mem); end
        step();
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL lw_reissue: got %b want 0", mem_req_valid); end
        stall_wb = 0;
        step();
        n_checks += 2;
        if (instruction_memory1 !== ADDI_I) begin n_errors++; $display("FAIL lw_advance: got %h want %h", instruction_memory1, ADDI_I); end
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL lw_idle: got %b want 0", mem_req_valid); end
    endtask

    task automatic test_flush();
        drive_mem(0, 3'b010, 32'h300, 32'h0);
        flush = 1;
        step();
        drive_alu();
        n_checks += 3;
        if (instruction_memory1 !== NOP_I) begin n_errors++; $display("FAIL fl_nop: got %h want %h", instruction_memory1, NOP_I); end
        if (opwrite_memory1 !== 1'b0 || opReg_memory1 !== 5'd0) begin
            n_errors++; $display("FAIL fl_ctrl: opw=%b opreg=%0d want 0", opwrite_memory1, opReg_memory1);
        end
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fl_noreq: got %b want 0", mem_req_valid); end
        step();
        drive_mem(0, 3'b010, 32'h304, 32'h0);
        mem_req_ready = 0;
        push(20'h304, 0, 32'h0, 4'b1111);
        step();
        drive_alu();
        flush = 1;
        step();
        n_checks += 2;
        if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL fl_issue_valid: got %b want 1", mem_req_valid); end
        if (ALU_result_memory1 !== 32'h304) begin n_errors++; $display("FAIL fl_issue_hold: got %h want 304", ALU_result_memory1); end
        flush = 0;
        mem_req_ready = 1;
        step();
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fl_complete: got %b want 0", mem_req_valid); end
    endtask

    task automatic test_align();
        drive_mem(0, 3'b001, 32'h101, 32'h0);
`ifndef MISALIGN_TRAP_EN
        push(20'h101, 0, 32'h0, 4'b0011);
`endif
        step();
        drive_alu();
        n_checks++;
`ifdef MISALIGN_TRAP_EN
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL lh_trap_noreq: got %b want 0", mem_req_valid); end
        n_checks++;
        if (misalign !== 1'b1) begin n_errors++; $display("FAIL lh_trap_flag: got %b want 1", misalign); end
`else
        if (mem_req_valid !== 1'b1 || mem_req_byte_en !== 4'b0011) begin
            n_errors++; $display("FAIL lh_issue: valid=%b be=%b want 1/0011", mem_req_valid, mem_req_byte_en);
        end
`endif
        drive_mem(1, 3'b001, 32'h102, 32'h0000BEEF);
        push(20'h102, 1, 32'hBEEFBEEF, 4'b1100);
        step();
        drive_alu();
        n_checks += 2;
        if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL sh_valid: got %b want 1", mem_req_valid); end
        if (mem_req_byte_en !== 4'b1100) begin n_errors++; $display("FAIL sh_be: got %b want 1100", mem_req_byte_en); end
`ifdef MISALIGN_TRAP_EN
        n_checks++;
        if (misalign !== 1'b0) begin n_errors++; $display("FAIL sh_noflag: got %b want 0", misalign); end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        logic [19:0] addrs[4];
        addrs = '{20'h10, 20'h11, 20'h12, 20'h13};
        drive_mem(1, 3'b010, 32'h10, 32'h11111111); push(20'h10, 1, 32'h11111111, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks += 2;
            if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, mem_req_valid); end
            if (mem_req_addr !== addrs[i]) begin n_errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, mem_req_addr, addrs[i]); end
            case (i)
                0: begin drive_mem(1, 3'b000, 32'h11, 32'h00000022); push(20'h11, 1, 32'h22222222, 4'b0010); end
                1: begin drive_mem(1, 3'b001, 32'h12, 32'h00003333); push(20'h12, 1, 32'h33333333, 4'b1100); end
                2: begin drive_mem(0, 3'b000, 32'h13, 32'h0);        push(20'h13, 0, 32'h0, 4'b1000); end
                default: drive_alu();
            endcase
        end
        step();
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_end: got %b want 0", mem_req_valid); end
    endtask

    task automatic test_reset_mid_issue();
        drive_mem(1, 3'b010, 32'h400, 32'h55555555);
        mem_req_ready = 0;
        step();
        drive_alu();
        n_checks++;
        if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL rmi_pre_valid: got %b want 1", mem_req_valid); end
        #2;
        reset = 0;
        #1;
        n_checks += 3;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rmi_valid_drop: got %b want 0", mem_req_valid); end
        if (instruction_memory1 !== NOP_I) begin n_errors++; $display("FAIL rmi_nop: got %h want %h", instruction_memory1, NOP_I); end
        if (stall_mem !== 1'b0) begin n_errors++; $display("FAIL rmi_stall: got %b want 0", stall_mem); end
        mem_req_ready = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 1;
        step();
        n_checks += 2;
        if (mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rmi_idle: got %b want 0", mem_req_valid); end
        if (instruction_memory1 !== ADDI_I) begin n_errors++; $display("FAIL rmi_resume: got %h want %h", instruction_memory1, ADDI_I); end
        drive_mem(1, 3'b010, 32'h404, 32'h66666666);
        push(20'h404, 1, 32'h66666666, 4'b1111);
        step();
        drive_alu();
        n_checks++;
        if (mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL rmi_reissue: got %b want 1", mem_req_valid); end
        step();
    endtask

    initial begin
        reset = 0; stall_wb = 0; mem_req_ready = 1; PC_execute = 20'h0;
        drive_alu();
        test_reset();
        test_sw();
        test_sb_backpressure();
        test_lw_stall_wb();
        test_flush();
        test_align();
        test_back_to_back();
        test_reset_mid_issue();
        repeat (2) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++; $display("FAIL sb_drain: %0d expected requests never seen, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
